// File: rtl/bus_bridge_pkg.sv
// Shared definitions for the UART-to-serial-bus bridge pair (master and slave side).
package bus_bridge_pkg;

  localparam int unsigned FRAME_WIDTH = 21;
  localparam int unsigned MODE_BIT    = 0;
  localparam int unsigned ADDR_LSB    = 1;
  localparam int unsigned DATA_LSB    = 13;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_ACK,
    ST_WDATA_WAIT,
    ST_WDATA,
    ST_RDATA,
    ST_UTX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bus_bridge_master_port.sv
// Bus-side engine: arbitrates, shifts address/write data out, collects read data, hands the byte to the UART.
module bus_bridge_master_port
  import bus_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   frame_valid,
  input  logic [FRAME_WIDTH-1:0] frame,
  output logic                   frame_take,
  output logic                   mbreq,
  input  logic                   mbgrant,
  output logic                   mwdata,
  output logic                   mmode,
  output logic                   mvalid,
  input  logic                   mrdata,
  input  logic                   svalid,
  input  logic                   sready,
  input  logic                   ack,
  output logic [DATA_WIDTH-1:0]  tx_byte,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   err_set,
  output logic                   busy
);

  localparam int unsigned AIW = $clog2(ADDR_WIDTH);
  localparam int unsigned DIW = $clog2(DATA_WIDTH);
  localparam logic [3:0] ADDR_LAST = 4'(ADDR_WIDTH - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] TO_LAST   = 4'(ACK_TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  assign busy    = (state_q != ST_IDLE);
  assign tx_byte = rdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    frame_take = 1'b0;
    mbreq      = 1'b0;
    mvalid     = 1'b0;
    mwdata     = 1'b0;
    mmode      = 1'b0;
    tx_start   = 1'b0;
    err_set    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_valid) begin
          frame_take = 1'b1;
          mode_d     = frame[MODE_BIT];
          addr_d     = frame[ADDR_LSB +: ADDR_WIDTH];
          data_d     = frame[DATA_LSB +: DATA_WIDTH];
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        mbreq = 1'b1;
        if (mbgrant) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        mbreq = 1'b1;
        mmode = mode_q;
        if (!mbgrant) begin
          state_d = ST_REQ;
        end else begin
          mvalid = 1'b1;
          mwdata = addr_q[cnt_q[AIW-1:0]];
          if (cnt_q == ADDR_LAST) state_d = ST_ACK;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_ACK: begin
        mbreq = 1'b1;
        if (ack)                   state_d = mode_q ? ST_WDATA_WAIT : ST_RDATA;
        else if (cnt_q == TO_LAST) begin
          err_set = 1'b1;
          state_d = ST_DONE;
        end else                   cnt_d = cnt_q + 1'b1;
      end
      ST_WDATA_WAIT: begin
        mbreq = 1'b1;
        if (sready) state_d = ST_WDATA;
      end
      ST_WDATA: begin
        mbreq = 1'b1;
        mmode = mode_q;
        // Losing grant mid-data replays the whole transaction from address bit 0.
        if (!mbgrant) begin
          state_d = ST_REQ;
        end else begin
          mvalid = 1'b1;
          mwdata = data_q[cnt_q[DIW-1:0]];
          if (cnt_q == DATA_LAST) state_d = ST_DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_RDATA: begin
        mbreq = 1'b1;
        if (svalid) begin
          rdata_d[cnt_q[DIW-1:0]] = mrdata;
          if (cnt_q == DATA_LAST) state_d = ST_UTX;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_UTX: begin
        // cnt_q sequences: 0 = launch byte, 1 = wait for tx_busy rise, 2 = wait for fall.
        mbreq = 1'b1;
        unique case (cnt_q)
          4'd0: begin
            tx_start = 1'b1;
            cnt_d    = 4'd1;
          end
          4'd1:    if (tx_busy)  cnt_d   = 4'd2;
          default: if (!tx_busy) state_d = ST_DONE;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/uart.sv
// Minimal 8N1-style UART: independent TX and RX widths, start bit 0, data LSB first, stop bit 1.
module uart #(
  parameter int unsigned CLOCKS_PER_PULSE = 5208,
  parameter int unsigned TX_DATA_WIDTH    = 8,
  parameter int unsigned RX_DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [TX_DATA_WIDTH-1:0] data_in,
  input  logic                     data_en,
  input  logic                     rx,
  output logic                     tx,
  output logic                     tx_busy,
  output logic [RX_DATA_WIDTH-1:0] data_out,
  output logic                     ready
);

  localparam int unsigned CW  = $clog2(CLOCKS_PER_PULSE) + 1;
  localparam int unsigned TXW = TX_DATA_WIDTH + 2;
  localparam int unsigned TBW = $clog2(TXW) + 1;
  localparam int unsigned BW  = $clog2(RX_DATA_WIDTH + 2) + 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] HALF_CLK = CW'(CLOCKS_PER_PULSE / 2);

  logic [TXW-1:0]           tx_shift_q, tx_shift_d;
  logic [TBW-1:0]           tx_left_q, tx_left_d;
  logic [CW-1:0]            tx_clk_q, tx_clk_d;
  logic [1:0]               rx_sync_q, rx_sync_d;
  logic                     rx_active_q, rx_active_d;
  logic [CW-1:0]            rx_clk_q, rx_clk_d;
  logic [BW-1:0]            rx_bit_q, rx_bit_d;
  logic [RX_DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                     ready_q, ready_d;
  logic                     rx_in;

  assign rx_in    = rx_sync_q[1];
  assign tx_busy  = (tx_left_q != '0);
  assign tx       = tx_busy ? tx_shift_q[0] : 1'b1;
  assign data_out = rx_shift_q;
  assign ready    = ready_q;

  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_left_d  = tx_left_q;
    tx_clk_d   = tx_clk_q;
    if (tx_left_q == '0) begin
      if (data_en) begin
        tx_shift_d = {1'b1, data_in, 1'b0};
        tx_left_d  = TBW'(TXW);
        tx_clk_d   = '0;
      end
    end else if (tx_clk_q == LAST_CLK) begin
      tx_clk_d   = '0;
      tx_shift_d = {1'b1, tx_shift_q[TXW-1:1]};
      tx_left_d  = tx_left_q - 1'b1;
    end else begin
      tx_clk_d = tx_clk_q + 1'b1;
    end
  end

  // Bit index 0 is the start bit (re-checked mid-bit), then data bits, then the stop bit.
  always_comb begin
    rx_sync_d   = {rx_sync_q[0], rx};
    rx_active_d = rx_active_q;
    rx_clk_d    = rx_clk_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    ready_d     = 1'b0;
    if (!rx_active_q) begin
      if (!rx_in) begin
        rx_active_d = 1'b1;
        rx_clk_d    = HALF_CLK;
        rx_bit_d    = '0;
      end
    end else if (rx_clk_q == LAST_CLK) begin
      rx_clk_d = '0;
      rx_bit_d = rx_bit_q + 1'b1;
      if (rx_bit_q == '0) begin
        if (rx_in) rx_active_d = 1'b0;
      end else if (rx_bit_q <= BW'(RX_DATA_WIDTH)) begin
        rx_shift_d = {rx_in, rx_shift_q[RX_DATA_WIDTH-1:1]};
      end else begin
        rx_active_d = 1'b0;
        ready_d     = rx_in;
      end
    end else begin
      rx_clk_d = rx_clk_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_shift_q  <= '1;
      tx_left_q   <= '0;
      tx_clk_q    <= '0;
      rx_sync_q   <= '1;
      rx_active_q <= 1'b0;
      rx_clk_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      ready_q     <= 1'b0;
    end else begin
      tx_shift_q  <= tx_shift_d;
      tx_left_q   <= tx_left_d;
      tx_clk_q    <= tx_clk_d;
      rx_sync_q   <= rx_sync_d;
      rx_active_q <= rx_active_d;
      rx_clk_q    <= rx_clk_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      ready_q     <= ready_d;
    end
  end

endmodule

// File: rtl/bus_bridge_master.sv
// Remote bridge endpoint: UART request frames in, replayed as local bus master transactions; read bytes back over UART.
module bus_bridge_master
  import bus_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH            = 8,
  parameter int unsigned ADDR_WIDTH            = 12,
  parameter int unsigned UART_CLOCKS_PER_PULSE = 5208,
  parameter int unsigned ACK_TIMEOUT           = 16
) (
  input  logic clk,
  input  logic rstn,
  output logic mbreq,
  input  logic mbgrant,
  output logic mwdata,
  output logic mmode,
  output logic mvalid,
  input  logic mrdata,
  input  logic svalid,
  input  logic sready,
  input  logic ack,
  input  logic u_rx,
  output logic u_tx,
  output logic busy,
  output logic err,
  output logic ovf
);

  logic [FRAME_WIDTH-1:0] rx_frame;
  logic                   rx_ready;
  logic [FRAME_WIDTH-1:0] buf_q, buf_d;
  logic                   buf_valid_q, buf_valid_d;
  logic                   err_q, err_d;
  logic                   ovf_q, ovf_d;
  logic                   frame_take;
  logic                   err_set;
  logic                   tx_start;
  logic                   tx_busy;
  logic [DATA_WIDTH-1:0]  tx_byte;

  uart #(
    .CLOCKS_PER_PULSE(UART_CLOCKS_PER_PULSE),
    .TX_DATA_WIDTH   (DATA_WIDTH),
    .RX_DATA_WIDTH   (FRAME_WIDTH)
  ) u_uart (
    .clk     (clk),
    .rstn    (rstn),
    .data_in (tx_byte),
    .data_en (tx_start),
    .rx      (u_rx),
    .tx      (u_tx),
    .tx_busy (tx_busy),
    .data_out(rx_frame),
    .ready   (rx_ready)
  );

  bus_bridge_master_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_port (
    .clk        (clk),
    .rstn       (rstn),
    .frame_valid(buf_valid_q),
    .frame      (buf_q),
    .frame_take (frame_take),
    .mbreq      (mbreq),
    .mbgrant    (mbgrant),
    .mwdata     (mwdata),
    .mmode      (mmode),
    .mvalid     (mvalid),
    .mrdata     (mrdata),
    .svalid     (svalid),
    .sready     (sready),
    .ack        (ack),
    .tx_byte    (tx_byte),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .err_set    (err_set),
    .busy       (busy)
  );

  // A frame arriving in the same cycle the engine drains the buffer is kept, not dropped.
  always_comb begin
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    ovf_d       = ovf_q;
    err_d       = err_q | err_set;
    if (frame_take) buf_valid_d = 1'b0;
    if (rx_ready) begin
      if (!buf_valid_q || frame_take) begin
        buf_d       = rx_frame;
        buf_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign err = err_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_bus_bridge_master.sv
// Scoreboard bench for bus_bridge_master: UART frames in, bus bits and UART bytes checked against queued expectations.
module tb_bus_bridge_master;

  localparam int CPP = 16;

  logic clk     = 1'b0;
  logic rstn    = 1'b0;
  logic mbgrant = 1'b0;
  logic mrdata  = 1'b0;
  logic svalid  = 1'b0;
  logic sready  = 1'b0;
  logic ack     = 1'b0;
  logic u_rx    = 1'b1;
  logic mbreq, mwdata, mmode, mvalid, u_tx, busy, err, ovf;

  int unsigned n_total    = 0;
  int unsigned n_bad      = 0;
  int unsigned n_rx_bytes = 0;

  logic [1:0] exp_bits[$];   // {mmode, mwdata}
  logic [7:0] exp_bytes[$];
  logic [1:0] mon_exp;
  logic [7:0] rx_byte;
  logic [7:0] rd_pat;

  bus_bridge_master #(
    .DATA_WIDTH           (8),
    .ADDR_WIDTH           (12),
    .UART_CLOCKS_PER_PULSE(CPP),
    .ACK_TIMEOUT          (16)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .mbreq  (mbreq),
    .mbgrant(mbgrant),
    .mwdata (mwdata),
    .mmode  (mmode),
    .mvalid (mvalid),
    .mrdata (mrdata),
    .svalid (svalid),
    .sready (sready),
    .ack    (ack),
    .u_rx   (u_rx),
    .u_tx   (u_tx),
    .busy   (busy),
    .err    (err),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [20:0] make_frame(input logic m, input logic [11:0] a, input logic [7:0] d);
    return {d, a, m};
  endfunction

  task automatic push_addr(input logic m, input logic [11:0] a, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) exp_bits.push_back({m, a[i]});
  endtask

  task automatic push_data(input logic m, input logic [7:0] d);
    for (int unsigned i = 0; i < 8; i++) exp_bits.push_back({m, d[i]});
  endtask

  task automatic uart_send(input logic [20:0] f);
    u_rx = 1'b0;
    tick(CPP);
    for (int i = 0; i < 21; i++) begin
      u_rx = f[i];
      tick(CPP);
    end
    u_rx = 1'b1;
    tick(CPP);
  endtask

  task automatic wait_req(input string tag);
    int unsigned n = 0;
    while (mbreq !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check(tag, 32'(mbreq), 32'd1);
  endtask

  task automatic wait_idle(input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_bits(input int unsigned left, input int unsigned budget, input string tag);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (exp_bits.size() > left && n < budget);
    check(tag, 32'(exp_bits.size()), 32'(left));
  endtask

  // Bus monitor: every valid bit is matched against the scoreboard.
  always @(negedge clk) begin
    if (rstn === 1'b1 && mvalid === 1'b1) begin
      if (exp_bits.size() == 0) begin
        check("extra_bus_bit", 32'({mmode, mwdata}), 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_bits.pop_front();
        check("bus_bit", 32'({mmode, mwdata}), 32'(mon_exp));
      end
    end
  end

  // UART receiver on u_tx, sampling mid-bit.
  initial begin
    wait (rstn === 1'b1);
    forever begin
      @(negedge u_tx);
      repeat (CPP / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPP) @(posedge clk);
        rx_byte[i] = u_tx;
      end
      repeat (CPP) @(posedge clk);
      check("uart_stop", 32'(u_tx), 32'd1);
      n_rx_bytes++;
      if (exp_bytes.size() == 0) check("extra_uart_byte", 32'(rx_byte), 32'hFFFF_FFFF);
      else                       check("uart_byte", 32'(rx_byte), 32'(exp_bytes.pop_front()));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(3);
    check("rst_mbreq", 32'(mbreq), 32'd0);
    check("rst_mvalid", 32'(mvalid), 32'd0);
    check("rst_mwdata", 32'(mwdata), 32'd0);
    check("rst_mmode", 32'(mmode), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_u_tx", 32'(u_tx), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rstn = 1'b1;
    tick(2);

    // Write transaction
    push_addr(1'b1, 12'h9AA, 12);
    push_data(1'b1, 8'hD5);
    uart_send(make_frame(1'b1, 12'h9AA, 8'hD5));
    wait_req("wr_req");
    check("wr_busy", 32'(busy), 32'd1);
    mbgrant = 1'b1; ack = 1'b1; sready = 1'b1;
    wait_bits(0, 200, "wr_bits");
    check("wr_req_last_bit", 32'(mbreq), 32'd1);
    @(negedge clk); #1;
    check("wr_done_req", 32'(mbreq), 32'd0);
    check("wr_done_busy", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("wr_idle", 32'(busy), 32'd0);
    mbgrant = 1'b0; ack = 1'b0; sready = 1'b0;

    // Read transaction returning 0xD4 over UART
    push_addr(1'b0, 12'h9AA, 12);
    exp_bytes.push_back(8'hD4);
    uart_send(make_frame(1'b0, 12'h9AA, 8'h00));
    wait_req("rd_req");
    mbgrant = 1'b1; ack = 1'b1;
    wait_bits(0, 200, "rd_addr_bits");
    tick(2);
    rd_pat = 8'hD4;
    for (int i = 0; i < 8; i++) begin
      svalid = 1'b1; mrdata = rd_pat[i];
      tick(1);
      if (i == 3) begin
        svalid = 1'b0; mrdata = 1'b1;
        tick(1);
      end
    end
    svalid = 1'b0; mrdata = 1'b0;
    tick(20);
    check("rd_busy_during_tx", 32'(busy), 32'd1);
    check("rd_req_during_tx", 32'(mbreq), 32'd1);
    wait_idle(400, "rd_idle");
    check("rd_nbytes", 32'(n_rx_bytes), 32'd1);
    check("rd_byte_drained", 32'(exp_bytes.size()), 32'd0);
    check("rd_tx_idle", 32'(u_tx), 32'd1);
    mbgrant = 1'b0; ack = 1'b0;

    // Ack timeout
    push_addr(1'b1, 12'h123, 12);
    uart_send(make_frame(1'b1, 12'h123, 8'h5A));
    wait_req("to_req");
    mbgrant = 1'b1; ack = 1'b0; sready = 1'b1;
    wait_bits(0, 200, "to_addr_bits");
    repeat (16) begin
      @(negedge clk); #1;
    end
    check("to_req_held", 32'(mbreq), 32'd1);
    check("to_err_early", 32'(err), 32'd0);
    @(negedge clk); #1;
    check("to_done_req", 32'(mbreq), 32'd0);
    check("to_err", 32'(err), 32'd1);
    @(negedge clk); #1;
    check("to_idle", 32'(busy), 32'd0);
    tick(20);
    check("to_no_byte", 32'(n_rx_bytes), 32'd1);
    check("to_err_sticky", 32'(err), 32'd1);
    mbgrant = 1'b0; sready = 1'b0;

    // Grant loss after address bit 5, replay from bit 0
    push_addr(1'b1, 12'h9AA, 6);
    push_addr(1'b1, 12'h9AA, 12);
    push_data(1'b1, 8'h3C);
    uart_send(make_frame(1'b1, 12'h9AA, 8'h3C));
    wait_req("gl_req");
    mbgrant = 1'b1;
    wait_bits(20, 100, "gl_first_bits");
    tick(1);
    mbgrant = 1'b0;
    @(negedge clk); #1;
    check("gl_mvalid_drop", 32'(mvalid), 32'd0);
    check("gl_req_held", 32'(mbreq), 32'd1);
    tick(3);
    check("gl_mvalid_low", 32'(mvalid), 32'd0);
    mbgrant = 1'b1; ack = 1'b1; sready = 1'b1;
    wait_bits(0, 200, "gl_replay_bits");
    wait_idle(20, "gl_idle");

    // Overflow: three frames while the slave stalls write data
    mbgrant = 1'b1; ack = 1'b1; sready = 1'b0;
    push_addr(1'b1, 12'h0F1, 12);
    push_data(1'b1, 8'hA7);
    push_addr(1'b1, 12'h3C6, 12);
    push_data(1'b1, 8'h18);
    uart_send(make_frame(1'b1, 12'h0F1, 8'hA7));
    uart_send(make_frame(1'b1, 12'h3C6, 8'h18));
    check("ovf_before_third", 32'(ovf), 32'd0);
    uart_send(make_frame(1'b1, 12'h555, 8'hEE));
    tick(2);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_pending", 32'(exp_bits.size()), 32'd28);
    check("ovf_busy", 32'(busy), 32'd1);
    sready = 1'b1;
    wait_bits(0, 400, "ovf_bits");
    wait_idle(20, "ovf_idle");
    tick(30);
    check("ovf_no_third", 32'(busy), 32'd0);
    mbgrant = 1'b0;

    // Asynchronous reset during write data
    ack = 1'b1; sready = 1'b1;
    push_addr(1'b1, 12'hABC, 12);
    push_data(1'b1, 8'h69);
    uart_send(make_frame(1'b1, 12'hABC, 8'h69));
    wait_req("rs_req");
    mbgrant = 1'b1;
    wait_bits(5, 200, "rs_bits");
    #2;
    rstn = 1'b0;
    #1;
    check("rs_mbreq", 32'(mbreq), 32'd0);
    check("rs_mvalid", 32'(mvalid), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_u_tx", 32'(u_tx), 32'd1);
    check("rs_err", 32'(err), 32'd0);
    check("rs_ovf", 32'(ovf), 32'd0);
    exp_bits.delete();
    tick(2);
    rstn = 1'b1;
    tick(10);
    check("rs_stay_idle", 32'(busy), 32'd0);
    check("rs_stay_noreq", 32'(mbreq), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
